// File: rtl/rv32_mod_load_store_unit_if.sv
// ---------------------------------------------------------------------------
// rv32_mod_load_store_unit_if
//   Bundles the request/response channel between the pipeline and the
//   load/store unit together with the request/acknowledge data bus.
//
//   Request side : req_valid, req_ready, ram_req[3:0], ram_wr, addr, wdata
//   Response side: rsp_valid, rsp_rdata, rsp_fault, stall
//   Data bus     : bus_req, bus_wr, bus_addr, bus_be[3:0], bus_wdata,
//                  bus_ack, bus_rdata, bus_err
//
//   modport master : the load/store unit (drives the bus, answers the pipeline)
//   modport slave  : the environment (pipeline + memory)
// ---------------------------------------------------------------------------
interface rv32_mod_load_store_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      ram_req;
    logic            ram_wr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_fault;
    logic            stall;
    logic            bus_req;
    logic            bus_wr;
    logic [XLEN-1:0] bus_addr;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_err;

    modport master (
        input  req_valid, ram_req, ram_wr, addr, wdata, bus_ack, bus_rdata, bus_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, stall,
               bus_req, bus_wr, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, ram_req, ram_wr, addr, wdata, bus_ack, bus_rdata, bus_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, stall,
               bus_req, bus_wr, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/rv32_mod_load_store_unit.sv
// ---------------------------------------------------------------------------
// rv32_mod_load_store_unit
//   Memory-access stage. Accepts one decoded load/store, runs a single
//   request/acknowledge cycle on the data bus and returns sign/zero-extended
//   load data (or a fault) as a one-cycle response.
//
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low reset
//     lsu    - rv32_mod_load_store_unit_if.master (request, response, bus)
//
//   Parameters:
//     XLEN           - data/address width (byte lanes assume 32)
//     TIMEOUT_CYCLES - bus-wait cycles before a forced abort
//
//   Optional feature: define RV32_LSU_TIMEOUT_EN to abort a bus access that
//   has not been acknowledged after TIMEOUT_CYCLES cycles. Without it the
//   unit waits for bus_ack indefinitely.
// ---------------------------------------------------------------------------
module rv32_mod_load_store_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rv32_mod_load_store_unit_if.master  lsu
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state_reg, state_next;
    logic            bus_req_reg, bus_wr_reg;
    logic [XLEN-1:0] bus_addr_reg, bus_wdata_reg;
    logic [3:0]      bus_be_reg;
    logic [1:0]      width_reg, lane_reg;
    logic            uns_reg, wr_reg;
    logic [XLEN-1:0] rdata_reg;
    logic            fault_reg;

    logic [1:0]      req_width;
    logic            req_bad;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] rdata_shift, load_ext;
    logic            timeout_hit;
    logic            unused_bits;

    assign req_width = lsu.ram_req[1:0];

    // Alignment / legality of the presented request.
    always_comb begin
        req_bad = 1'b0;
        case (req_width)
            2'b01:   req_bad = lsu.addr[0];
            2'b10:   req_bad = |lsu.addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = lsu.wdata;
        case (req_width)
            2'b00: begin
                be_calc    = 4'b0001 << lsu.addr[1:0];
                wdata_calc = {4{lsu.wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << lsu.addr[1:0];
                wdata_calc = {2{lsu.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: move the addressed lane down to bit 0, then extend.
    assign rdata_shift = lsu.bus_rdata >> {lane_reg, 3'b000};

    always_comb begin
        load_ext = rdata_shift;
        case (width_reg)
            2'b00:   load_ext = {{24{~uns_reg & rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01:   load_ext = {{16{~uns_reg & rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_ext = rdata_shift;
        endcase
    end

`ifdef RV32_LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_reg;

    // Fires in the TIMEOUT_CYCLES-th unacknowledged BUS cycle, so bus_req is
    // held for exactly TIMEOUT_CYCLES cycles. An ack in that cycle still wins.
    assign timeout_hit = (state_reg == BUS) && !lsu.bus_ack &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg != BUS) begin
            wait_cnt_reg <= '0;
        end else if (!lsu.bus_ack) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    assign unused_bits = lsu.ram_req[3];
`else
    assign timeout_hit = 1'b0;
    assign unused_bits = ^{lsu.ram_req[3], 1'(TIMEOUT_CYCLES)};
`endif

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (lsu.req_valid) state_next = req_bad ? RESP : BUS;
            BUS:     if (lsu.bus_ack || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bus_req_reg   <= 1'b0;
            bus_wr_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
            width_reg     <= '0;
            lane_reg      <= '0;
            uns_reg       <= 1'b0;
            wr_reg        <= 1'b0;
            rdata_reg     <= '0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (lsu.req_valid) begin
                        width_reg <= req_width;
                        lane_reg  <= lsu.addr[1:0];
                        uns_reg   <= lsu.ram_req[2];
                        wr_reg    <= lsu.ram_wr;
                        rdata_reg <= '0;
                        fault_reg <= req_bad;
                        // Faulting requests never touch the bus.
                        if (!req_bad) begin
                            bus_req_reg   <= 1'b1;
                            bus_wr_reg    <= lsu.ram_wr;
                            bus_addr_reg  <= {lsu.addr[XLEN-1:2], 2'b00};
                            bus_be_reg    <= be_calc;
                            bus_wdata_reg <= wdata_calc;
                        end
                    end
                end
                BUS: begin
                    if (lsu.bus_ack) begin
                        bus_req_reg <= 1'b0;
                        fault_reg   <= lsu.bus_err;
                        rdata_reg   <= (wr_reg || lsu.bus_err) ? '0 : load_ext;
                    end else if (timeout_hit) begin
                        bus_req_reg <= 1'b0;
                        fault_reg   <= 1'b1;
                        rdata_reg   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu.req_ready = (state_reg == IDLE);
    assign lsu.rsp_valid = (state_reg == RESP);
    assign lsu.rsp_rdata = (state_reg == RESP) ? rdata_reg : '0;
    assign lsu.rsp_fault = (state_reg == RESP) && fault_reg;
    // In IDLE the unit is always ready, and RESP is the cycle the op retires,
    // so the pipeline only has to be held while the bus access is in flight.
    assign lsu.stall     = (state_reg == BUS);
    assign lsu.bus_req   = bus_req_reg;
    assign lsu.bus_wr    = bus_wr_reg;
    assign lsu.bus_addr  = bus_addr_reg;
    assign lsu.bus_be    = bus_be_reg;
    assign lsu.bus_wdata = bus_wdata_reg;
endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
module tb_rv32_mod_load_store_unit;
    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rv32_mod_load_store_unit_if #(.XLEN(XLEN)) bif();

    rv32_mod_load_store_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic int size_of(input logic [1:0] w);
        return 1 << w;
    endfunction

    function automatic logic m_bad(input logic [1:0] w, input logic [1:0] a);
        if (w == 2'b11) return 1'b1;
        return (int'(a) % size_of(w)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] w, input logic [1:0] a);
        int s = size_of(w);
        return 4'(((1 << s) - 1) << a);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
        logic [31:0] r;
        int s = size_of(w);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic uns,
                                           input logic [1:0] a, input logic [31:0] rd);
        longint v = 0;
        int s = size_of(w);
        for (int k = 0; k < s; k++) v = v | (longint'(rd[8*(int'(a)+k) +: 8]) << (8*k));
        if (!uns && s < 4 && v[8*s-1]) v = v - (longint'(1) << (8*s));
        return v[31:0];
    endfunction

    bit          m_on_bus, m_resp_due;
    logic [1:0]  m_w, m_lane;
    logic        m_uns, m_wr, m_fault;
    logic [31:0] m_baddr, m_bwdata, m_rdata;
    logic [3:0]  m_bbe;
    int          m_wait;

    always @(negedge rst_n) begin
        m_on_bus   = 0;
        m_resp_due = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_resp_due) begin
                m_resp_due = 0;
            end else if (m_on_bus) begin
                if (bif.bus_ack) begin
                    m_on_bus   = 0;
                    m_resp_due = 1;
                    m_fault    = bif.bus_err;
                    m_rdata    = (m_wr || bif.bus_err) ? 32'h0 : m_load(m_w, m_uns, m_lane, bif.bus_rdata);
                end
`ifdef RV32_LSU_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_on_bus   = 0;
                        m_resp_due = 1;
                        m_fault    = 1;
                        m_rdata    = 32'h0;
                    end
                end
`endif
            end else if (bif.req_valid) begin
                m_w    = bif.ram_req[1:0];
                m_uns  = bif.ram_req[2];
                m_wr   = bif.ram_wr;
                m_lane = bif.addr[1:0];
                if (m_bad(m_w, m_lane)) begin
                    m_resp_due = 1;
                    m_fault    = 1;
                    m_rdata    = 32'h0;
                end else begin
                    m_on_bus = 1;
                    m_wait   = 0;
                    m_baddr  = {bif.addr[31:2], 2'b00};
                    m_bbe    = m_be(m_w, m_lane);
                    m_bwdata = m_wdata(m_w, bif.wdata);
                end
            end
        end
    end

    // Compare process: every cycle, on the inactive edge.
    always @(negedge clk) begin
        chk("req_ready", bif.req_ready, !(m_on_bus || m_resp_due));
        chk("stall", bif.stall, m_on_bus);
        chk("bus_req", bif.bus_req, m_on_bus);
        chk("rsp_valid", bif.rsp_valid, m_resp_due);
        if (m_on_bus) begin
            chk("bus_wr", bif.bus_wr, m_wr);
            chk("bus_addr", bif.bus_addr, m_baddr);
            chk("bus_be", bif.bus_be, m_bbe);
            chk("bus_wdata", bif.bus_wdata, m_bwdata);
        end
        if (m_resp_due) begin
            chk("rsp_rdata", bif.rsp_rdata, m_rdata);
            chk("rsp_fault", bif.rsp_fault, m_fault);
        end
    end

    // ---------------- driver ----------------
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic        o_fault, o_seen, o_wr;
    logic [3:0]  o_be;
    int          o_lat;

    task automatic do_txn(input logic [3:0] rq, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int dly, input logic [31:0] rd,
                          input logic err, input bit noise,
                          output logic [31:0] r_rdata, output logic r_fault, output logic r_seen,
                          output logic [31:0] r_addr, output logic [31:0] r_wdata,
                          output logic [3:0] r_be, output logic r_wr, output int r_lat);
        int  waited = 0;
        int  lim = 0;
        bit  done = 0;
        r_rdata = 'x; r_fault = 'x; r_seen = 0; r_addr = 'x; r_wdata = 'x; r_be = 'x; r_wr = 'x;
        r_lat = 0;
        bif.req_valid = 1'b1;
        bif.ram_req   = rq;
        bif.ram_wr    = wr;
        bif.addr      = a;
        bif.wdata     = d;
        while (!bif.req_ready && lim < 50) begin
            @(posedge clk); #1;
            lim++;
        end
        @(posedge clk); #1;
        bif.req_valid = noise ? 1'($urandom % 2) : 1'b0;
        if (noise) begin
            bif.addr    = $urandom;
            bif.wdata   = $urandom;
            bif.ram_req = 4'($urandom);
        end
        while (!done && r_lat < 400) begin
            if (bif.rsp_valid) begin
                r_rdata = bif.rsp_rdata;
                r_fault = bif.rsp_fault;
                done = 1;
            end else begin
                if (bif.bus_req) begin
                    if (!r_seen) begin
                        r_addr = bif.bus_addr; r_wdata = bif.bus_wdata;
                        r_be = bif.bus_be; r_wr = bif.bus_wr;
                    end
                    r_seen = 1;
                    if (waited == dly) begin
                        bif.bus_ack = 1'b1; bif.bus_rdata = rd; bif.bus_err = err;
                    end else begin
                        bif.bus_ack = 1'b0; bif.bus_rdata = $urandom; bif.bus_err = 1'($urandom);
                    end
                    waited++;
                end else begin
                    bif.bus_ack = noise ? 1'($urandom % 2) : 1'b0;
                    bif.bus_err = 1'($urandom);
                end
                @(posedge clk); #1;
                bif.bus_ack = 1'b0;
                r_lat++;
            end
        end
        bif.req_valid = 1'b0;
        bif.bus_ack   = 1'b0;
        chk("rsp_arrives", 32'(done), 32'd1);
        if (done) begin
            @(posedge clk); #1;
        end
    endtask

    int  hi;
    bit  rsp_seen, flt_seen;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid = 0; bif.ram_req = 0; bif.ram_wr = 0; bif.addr = 0; bif.wdata = 0;
        bif.bus_ack = 0; bif.bus_rdata = 0; bif.bus_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", bif.req_ready, 1);
        chk("reset_bus_req", bif.bus_req, 0);
        chk("reset_rsp_valid", bif.rsp_valid, 0);
        chk("reset_stall", bif.stall, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word load, ack after 3 cycles.
        do_txn(4'b0010, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 0,
               o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
        chk("wl_bus_addr", o_addr, 32'h100);
        chk("wl_be", o_be, 4'b1111);
        chk("wl_rdata", o_rdata, 32'hDEADBEEF);
        chk("wl_fault", o_fault, 0);

        // Signed and unsigned byte load from lane 3.
        do_txn(4'b0000, 0, 32'h103, 32'h0, 1, 32'h80FF_FFFF, 0, 0,
               o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
        chk("lb_be", o_be, 4'b1000);
        chk("lb_rdata", o_rdata, 32'hFFFFFF80);
        do_txn(4'b0100, 0, 32'h103, 32'h0, 0, 32'h80FF_FFFF, 0, 0,
               o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
        chk("lbu_rdata", o_rdata, 32'h00000080);
        chk("min_latency", o_lat, 1);

        // Half store to upper half.
        do_txn(4'b0001, 1, 32'h202, 32'h1234ABCD, 2, 32'h55555555, 0, 0,
               o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
        chk("sh_bus_addr", o_addr, 32'h200);
        chk("sh_be", o_be, 4'b1100);
        chk("sh_wdata", o_wdata, 32'hABCDABCD);
        chk("sh_wr", o_wr, 1);
        chk("sh_rdata", o_rdata, 0);

        // Misaligned word: no bus cycle, response in the next cycle.
        do_txn(4'b0010, 0, 32'h301, 32'h0, 0, 32'h0, 0, 0,
               o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
        chk("mis_bus_seen", o_seen, 0);
        chk("mis_fault", o_fault, 1);
        chk("mis_latency", o_lat, 0);

        // Bus error.
        do_txn(4'b0010, 0, 32'h40, 32'h0, 1, 32'h12345678, 1, 0,
               o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
        chk("err_fault", o_fault, 1);
        chk("err_rdata", o_rdata, 0);

        // Asynchronous reset while waiting on the bus.
        bif.req_valid = 1; bif.ram_req = 4'b0010; bif.ram_wr = 0; bif.addr = 32'h600;
        @(posedge clk); #1;
        bif.req_valid = 0;
        chk("rst_bus_req_before", bif.bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus_req_async", bif.bus_req, 0);
        chk("rst_req_ready_async", bif.req_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            rsp_seen |= bif.rsp_valid;
            @(posedge clk); #1;
        end
        chk("rst_no_rsp", rsp_seen, 0);
        chk("rst_ready_after", bif.req_ready, 1);

        // Unacknowledged bus access.
        bif.req_valid = 1; bif.ram_req = 4'b0010; bif.ram_wr = 0; bif.addr = 32'h500;
        bif.bus_rdata = 32'hCAFEF00D; bif.bus_err = 0;
        @(posedge clk); #1;
        bif.req_valid = 0;
        hi = 0;
`ifdef RV32_LSU_TIMEOUT_EN
        flt_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bif.bus_req) hi++;
            if (bif.rsp_valid) flt_seen |= bif.rsp_fault;
            @(posedge clk); #1;
        end
        chk("to_bus_cycles", hi, TO);
        chk("to_fault", flt_seen, 1);
`else
        for (int i = 0; i < 100; i++) begin
            if (bif.bus_req) hi++;
            @(posedge clk); #1;
        end
        chk("hang_bus_cycles", hi, 100);
        bif.bus_ack = 1;
        @(posedge clk); #1;
        bif.bus_ack = 0;
        chk("hang_rsp_valid", bif.rsp_valid, 1);
        chk("hang_rdata", bif.rsp_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
`endif

        // Randomized traffic with noise on idle-bus ack and held requests.
        for (int n = 0; n < 150; n++) begin
            do_txn(4'($urandom), 1'($urandom), $urandom, $urandom, int'($urandom % 6),
                   $urandom, ($urandom % 10) == 0, 1,
                   o_rdata, o_fault, o_seen, o_addr, o_wdata, o_be, o_wr, o_lat);
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
